// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and helpers for the sort engine
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int phase_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sort_cx.sv
// rtl/sort_cx.sv - combinational compare-exchange of two elements
module sort_cx #(
  parameter int W      = 4,
  parameter int SIGNED = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         desc,
  output logic [W-1:0] lo_pos,
  output logic [W-1:0] hi_pos,
  output logic         swapped
);

  logic gt;
  logic lt;

  always_comb begin
    if (SIGNED != 0) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    // equal values never swap, keeping the exchange stable
    swapped = desc ? lt : gt;
    lo_pos  = swapped ? b : a;
    hi_pos  = swapped ? a : b;
  end

endmodule

// File: rtl/sort_engine.sv
// rtl/sort_engine.sv - sequential odd-even transposition sorter with handshakes
module sort_engine
  import sort_pkg::*;
#(
  parameter int N          = 4,
  parameter int W          = 4,
  parameter int SIGNED     = 0,
  parameter int EARLY_EXIT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*W-1:0]          in_data,
  input  logic                    in_desc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*W-1:0]          out_data,
  output logic [phase_w(N)-1:0]   out_phases
);

  localparam int PW = phase_w(N);
  localparam logic [PW-1:0] LAST_PHASE = PW'(N - 1);

  if (N < 2) begin : g_bad_n
    $error("sort_engine: N must be at least 2");
  end

  state_t          state;
  state_t          state_nx;
  logic [N*W-1:0]  data_q;
  logic [N*W-1:0]  data_nx;
  logic            desc_q;
  logic [PW-1:0]   phase_q;
  logic            prev_swap_q;
  logic            any_swap;
  logic            sort_last;
  logic [N-2:0]    cx_swap;
  logic [W-1:0]    cx_lo [N-1];
  logic [W-1:0]    cx_hi [N-1];

  for (genvar i = 0; i < N - 1; i++) begin : g_cx
    sort_cx #(.W(W), .SIGNED(SIGNED)) u_cx (
      .a       (data_q[i*W +: W]),
      .b       (data_q[(i+1)*W +: W]),
      .desc    (desc_q),
      .lo_pos  (cx_lo[i]),
      .hi_pos  (cx_hi[i]),
      .swapped (cx_swap[i])
    );
  end

  // Pairs starting at an index of the same parity as the phase are active;
  // they never overlap, so every active pair can be written in one edge.
  always_comb begin
    data_nx  = data_q;
    any_swap = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if (i[0] == phase_q[0]) begin
        data_nx[i*W +: W]     = cx_lo[i];
        data_nx[(i+1)*W +: W] = cx_hi[i];
        any_swap              = any_swap | cx_swap[i];
      end
    end
  end

  always_comb begin
    sort_last = (phase_q == LAST_PHASE);
    if (EARLY_EXIT != 0 && phase_q != '0 && !any_swap && !prev_swap_q) begin
      sort_last = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = SORT;
      SORT:    if (sort_last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      desc_q      <= 1'b0;
      phase_q     <= '0;
      prev_swap_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q      <= in_data;
            desc_q      <= in_desc;
            phase_q     <= '0;
            prev_swap_q <= 1'b0;
          end
        end
        SORT: begin
          data_q      <= data_nx;
          phase_q     <= phase_q + PW'(1);
          prev_swap_q <= any_swap;
        end
        default: ;
      endcase
    end
  end

  assign out_data   = data_q;
  assign out_phases = phase_q;

endmodule

// File: tb/tb_sort_engine.sv
// tb/tb_sort_engine.sv - directed self-checking bench for sort_engine
module tb_sort_engine;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_desc;
  logic [2:0]  in_valid_v;
  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [2:0]  out_ready_v;
  logic [15:0] out_data_v   [3];
  logic [2:0]  out_phases_v [3];

  int errors;
  int checks;

  // 0: plain unsigned, 1: early exit, 2: signed compare
  sort_engine #(.N(4), .W(4), .SIGNED(0), .EARLY_EXIT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data), .in_desc(in_desc), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .out_data(out_data_v[0]), .out_phases(out_phases_v[0])
  );

  sort_engine #(.N(4), .W(4), .SIGNED(0), .EARLY_EXIT(1)) dut_ee (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data), .in_desc(in_desc), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .out_data(out_data_v[1]), .out_phases(out_phases_v[1])
  );

  sort_engine #(.N(4), .W(4), .SIGNED(1), .EARLY_EXIT(0)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data), .in_desc(in_desc), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .out_data(out_data_v[2]), .out_phases(out_phases_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one transaction into instance idx; lat counts edges from acceptance to out_valid.
  task automatic run(input int idx, input logic [15:0] d, input logic desc,
                     output int lat, output logic [15:0] res, output logic [2:0] ph);
    int w;
    in_data         = d;
    in_desc         = desc;
    in_valid_v[idx] = 1'b1;
    w = 0;
    while (!in_ready_v[idx] && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    in_valid_v[idx] = 1'b0;
    lat = 99;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid_v[idx]) begin
        lat = c;
        break;
      end
    end
    res = out_data_v[idx];
    ph  = out_phases_v[idx];
    out_ready_v[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (in_ready_v !== 3'b111) begin errors++; $display("FAIL reset_in_ready got=%b exp=111", in_ready_v); end
    checks++; if (out_valid_v !== 3'b000) begin errors++; $display("FAIL reset_out_valid got=%b exp=000", out_valid_v); end
    checks++; if (out_data_v[0] !== 16'h0000) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", out_data_v[0]); end
    checks++; if (out_phases_v[0] !== 3'd0) begin errors++; $display("FAIL reset_out_phases got=%0d exp=0", out_phases_v[0]); end
  endtask

  task automatic test_ascending();
    int lat; logic [15:0] res; logic [2:0] ph;
    run(0, 16'h1329, 1'b0, lat, res, ph);
    checks++; if (res !== 16'h9321) begin errors++; $display("FAIL asc_data got=%h exp=9321", res); end
    checks++; if (ph !== 3'd4) begin errors++; $display("FAIL asc_phases got=%0d exp=4", ph); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL asc_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_descending();
    int lat; logic [15:0] res; logic [2:0] ph;
    run(0, 16'h1329, 1'b1, lat, res, ph);
    checks++; if (res !== 16'h1239) begin errors++; $display("FAIL desc_data got=%h exp=1239", res); end
    checks++; if (ph !== 3'd4) begin errors++; $display("FAIL desc_phases got=%0d exp=4", ph); end
  endtask

  task automatic test_early_exit();
    int lat; logic [15:0] res; logic [2:0] ph;
    run(1, 16'h4321, 1'b0, lat, res, ph);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ee_latency got=%0d exp=2", lat); end
    checks++; if (ph !== 3'd2) begin errors++; $display("FAIL ee_phases got=%0d exp=2", ph); end
    checks++; if (res !== 16'h4321) begin errors++; $display("FAIL ee_data got=%h exp=4321", res); end
    run(0, 16'h4321, 1'b0, lat, res, ph);
    checks++; if (lat !== 4) begin errors++; $display("FAIL noee_latency got=%0d exp=4", lat); end
    checks++; if (ph !== 3'd4) begin errors++; $display("FAIL noee_phases got=%0d exp=4", ph); end
    run(1, 16'h1329, 1'b0, lat, res, ph);
    checks++; if (res !== 16'h9321) begin errors++; $display("FAIL ee_unsorted_data got=%h exp=9321", res); end
    checks++; if (ph !== 3'd4) begin errors++; $display("FAIL ee_unsorted_phases got=%0d exp=4", ph); end
  endtask

  task automatic test_signed();
    int lat; logic [15:0] res; logic [2:0] ph;
    run(2, 16'h11F1, 1'b0, lat, res, ph);
    checks++; if (res !== 16'h111F) begin errors++; $display("FAIL signed_data got=%h exp=111F", res); end
    run(0, 16'h11F1, 1'b0, lat, res, ph);
    checks++; if (res !== 16'hF111) begin errors++; $display("FAIL unsigned_data got=%h exp=F111", res); end
  endtask

  task automatic test_backpressure();
    int w;
    in_data       = 16'h1329;
    in_desc       = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_data = 16'hAAAA;
    w = 0;
    while (!out_valid_v[0] && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    checks++; if (out_valid_v[0] !== 1'b1) begin errors++; $display("FAIL bp_reach_done got=%b exp=1", out_valid_v[0]); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid_v[0] !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", c, out_valid_v[0]); end
      checks++; if (out_data_v[0] !== 16'h9321) begin errors++; $display("FAIL bp_out_data cyc=%0d got=%h exp=9321", c, out_data_v[0]); end
      checks++; if (out_phases_v[0] !== 3'd4) begin errors++; $display("FAIL bp_out_phases cyc=%0d got=%0d exp=4", c, out_phases_v[0]); end
      checks++; if (in_ready_v[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, in_ready_v[0]); end
    end
    in_valid_v[0]  = 1'b0;
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[0] = 1'b0;
    checks++; if (in_ready_v[0] !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready_v[0]); end
    checks++; if (out_valid_v[0] !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid_v[0]); end
  endtask

  task automatic test_reset_mid_sort();
    int lat; logic [15:0] res; logic [2:0] ph;
    in_data       = 16'h1329;
    in_desc       = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (in_ready_v[0] !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready_v[0]); end
    checks++; if (out_valid_v[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid_v[0]); end
    checks++; if (out_data_v[0] !== 16'h0000) begin errors++; $display("FAIL mid_rst_out_data got=%h exp=0000", out_data_v[0]); end
    run(0, 16'h1329, 1'b0, lat, res, ph);
    checks++; if (res !== 16'h9321) begin errors++; $display("FAIL mid_rst_resort got=%h exp=9321", res); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL mid_rst_latency got=%0d exp=4", lat); end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    in_data     = '0;
    in_desc     = 1'b0;
    in_valid_v  = '0;
    out_ready_v = '0;
    test_reset();
    test_ascending();
    test_descending();
    test_early_exit();
    test_signed();
    test_backpressure();
    test_reset_mid_sort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
